automata_monitor_stage: RTL and testbench
=========================================

# automata_monitor_stage

Parametrised monitor stage for the RM runtime-verification cluster. It registers the incoming trace symbol and forwards it, with reset, to the next stage. It also runs NUM_CH programmable symbol-matching automata, one per LTL property, in parallel on the same symbol stream. Each automaton raises a report pulse when it enters an accepting state; reports are also latched as sticky flags and, optionally, counted.

## Interface
Parameters:
- SYM_W, 8, symbol width in bits
- NUM_CH, 3, number of automaton channels
- NUM_ST, 8, states per channel; power of 2, ≥2; ST_W = log2(NUM_ST)
- CNT_W, 16, report counter width
- PIPE_DEPTH, 1, symbol/reset forwarding register stages (≥1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- run  in  1  advance enable
- top_symbols  in  SYM_W  trace symbol
- cfg_we  in  1  table write strobe
- cfg_ch  in  max(1,log2(NUM_CH))  target channel
- cfg_st  in  ST_W  target state
- cfg_data  in  2*SYM_W+2*ST_W+1  {match_val, match_mask, next_st, fail_st, accept}
- cfg_rej  out  1  one-cycle pulse: write dropped
- clear_sticky  in  NUM_CH  per-channel sticky clear
- report  out  NUM_CH  one-cycle accept pulse
- report_sticky  out  NUM_CH  latched report
- report_cnt  out  NUM_CH*CNT_W  per-channel counters, channel 0 in LSBs
- out_symbols  out  SYM_W  forwarded symbol
- out_reset  out  1  forwarded reset

## Operation
- Each channel holds a NUM_ST-entry table and a current-state register. The start state is 0.
- Match rule: the symbol matches when (top_symbols & match_mask) == (match_val & match_mask).
- With run=1, the state register loads next_st on a match and fail_st otherwise.
- With run=0, all channel state is held and report stays 0.
- report[c] = 1 when the newly loaded state has accept=1. Automata keep running after an accept; there is no halt.
- report_sticky[c]: set by report[c], cleared by clear_sticky[c]. If both occur in the same cycle, set wins.
- Config writes:
  - A write is accepted only when run=0 and cfg_ch < NUM_CH.
  - Otherwise the write is dropped and cfg_rej pulses in the next cycle.
  - An accepted write updates the entry in the next cycle. Current state is untouched.
- Forwarding:
  - out_symbols is top_symbols delayed by PIPE_DEPTH registers. These registers advance only when run=1.
  - out_reset is reset delayed by PIPE_DEPTH registers. These registers advance every cycle, independent of run.
- Reset has priority over run, cfg_we and clear_sticky. It clears:
  - state to 0
  - all table entries to zero (mask 0, so every symbol matches → next 0, no accept)
  - sticky flags, counters, out_symbols, report and cfg_rej

## Timing
- Reset values: report=0, report_sticky=0, report_cnt=0, cfg_rej=0, out_symbols=0. out_reset pipeline registers reset to 1.
- Report latency: symbol sampled at edge t (run=1) → state updated and report asserted after edge t, visible in cycle t+1.
- Sticky flag and counter update on the same edge as report.
- Forward latency: PIPE_DEPTH cycles of run=1 for out_symbols; PIPE_DEPTH cycles for out_reset.
- Config: write at edge t is usable for the symbol sampled at edge t+1 at the earliest.
- Reset asserted mid-trace: takes effect at the next edge. Any report from that cycle's symbol is suppressed.

## Configuration
- MONITOR_REPORT_CNT_EN defined:
  - report_cnt[c] increments by 1 on each report[c].
  - It saturates at 2^CNT_W−1 and is cleared only by reset.
- Undefined: no counter registers are built and report_cnt is tied to 0. All other behaviour is identical.

## Structure
- Package monitor_pkg holds:
  - the state-entry struct (match_val, match_mask, next_st, fail_st, accept), parametrised via localparam widths
  - the cfg_data field offsets
  - the counter saturation constant
- Sub-module automata_dfa_channel contains one table, the state register, the report, sticky and counter logic. It is instantiated NUM_CH times with a generate loop.
- The top level contains the forwarding pipeline and config decode.

## Test plan
- Reset with out_reset observation, PIPE_DEPTH=1: assert reset for 3 cycles → out_reset=1 one cycle after assertion. All outputs 0. Any symbol produces no report.
- Single-property match:
  - Program channel 0 as state0: val 0x41 mask 0xFF next 1 fail 0; state1: val 0x42 next 2 fail 0; state2: accept, mask 0.
  - Feed 0x41,0x42 → report[0] pulses one cycle after 0x42. Sticky stays 1. Counter=1.
- run gating: stream 0x41, run=0 for 4 cycles, then 0x42 → state held, out_symbols unchanged while run=0, report after 0x42.
- Config rejection: cfg_we while run=1, or cfg_ch=3 with NUM_CH=3 → cfg_rej pulses next cycle; table unchanged.
- Sticky race: clear_sticky[1]=1 in the same cycle as report[1] → sticky remains 1. A clear in the following cycle → 0.
- Saturation with CNT_W=2 and MONITOR_REPORT_CNT_EN: trigger 5 accepts → count 3. Without the macro, report_cnt stays 0.

Source files
------------

// File: rtl/monitor_pkg.sv
// Shared types and constants for the automata monitor stage: table-entry
// layout, cfg_data field offsets and the counter saturation constant.
package monitor_pkg;

  localparam int unsigned DEF_SYM_W = 8;
  localparam int unsigned DEF_ST_W  = 3;

  // cfg_data layout, MSB to LSB: {match_val, match_mask, next_st, fail_st, accept}
  typedef struct packed {
    logic [DEF_SYM_W-1:0] match_val;
    logic [DEF_SYM_W-1:0] match_mask;
    logic [DEF_ST_W-1:0]  next_st;
    logic [DEF_ST_W-1:0]  fail_st;
    logic                 accept;
  } mon_entry_t;

  localparam int unsigned ACCEPT_BIT = 0;
  localparam int unsigned FAIL_LSB   = 1;

  function automatic int unsigned next_lsb(input int unsigned st_w);
    return 1 + st_w;
  endfunction

  function automatic int unsigned mask_lsb(input int unsigned st_w);
    return 1 + 2 * st_w;
  endfunction

  function automatic int unsigned val_lsb(input int unsigned sym_w, input int unsigned st_w);
    return 1 + 2 * st_w + sym_w;
  endfunction

  function automatic int unsigned cfg_width(input int unsigned sym_w, input int unsigned st_w);
    return 2 * sym_w + 2 * st_w + 1;
  endfunction

  // All-ones source for counter saturation; truncated to the counter width.
  localparam logic [63:0] CNT_SAT_ALL = '1;

endpackage

// File: rtl/automata_dfa_channel.sv
// One programmable symbol-matching automaton: table, state, report, sticky flag
// and (with MONITOR_REPORT_CNT_EN defined) a saturating report counter.
module automata_dfa_channel
  import monitor_pkg::*;
#(
  parameter  int SYM_W  = 8,
  parameter  int NUM_ST = 8,
  parameter  int CNT_W  = 16,
  localparam int ST_W   = $clog2(NUM_ST),
  localparam int CFG_W  = cfg_width(SYM_W, ST_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [SYM_W-1:0] sym,
  input  logic             wr_en,
  input  logic [ST_W-1:0]  wr_st,
  input  logic [CFG_W-1:0] wr_data,
  input  logic             clear,
  output logic             report,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);

  localparam int unsigned NEXT_LSB = next_lsb(ST_W);
  localparam int unsigned MASK_LSB = mask_lsb(ST_W);
  localparam int unsigned VAL_LSB  = val_lsb(SYM_W, ST_W);

  logic [CFG_W-1:0] tbl_q [NUM_ST];
  logic [CFG_W-1:0] tbl_d [NUM_ST];
  logic [ST_W-1:0]  state_q, state_d;
  logic             report_q, report_d;
  logic             sticky_q, sticky_d;
  logic [SYM_W-1:0] cur_val, cur_mask;
  logic             sym_match;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    tbl_d    = tbl_q;
    state_d  = state_q;
    report_d = 1'b0;
    if (wr_en) tbl_d[wr_st] = wr_data;

    cur_val   = tbl_q[state_q][VAL_LSB +: SYM_W];
    cur_mask  = tbl_q[state_q][MASK_LSB +: SYM_W];
    sym_match = ((sym ^ cur_val) & cur_mask) == '0;

    if (run) begin
      state_d  = sym_match ? tbl_q[state_q][NEXT_LSB +: ST_W]
                           : tbl_q[state_q][FAIL_LSB +: ST_W];
      report_d = tbl_q[state_d][ACCEPT_BIT];
    end
    // A new report wins over a simultaneous clear.
    sticky_d = report_d | (sticky_q & ~clear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the table is reset on purpose; the all-zero entry is a defined idle
      // automaton, so this storage is flops rather than an unreset RAM.
      for (int i = 0; i < NUM_ST; i++) tbl_q[i] <= '0;
      state_q  <= '0;
      report_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      tbl_q    <= tbl_d;
      state_q  <= state_d;
      report_q <= report_d;
      sticky_q <= sticky_d;
    end
  end

  assign report = report_q;
  assign sticky = sticky_q;

`ifdef MONITOR_REPORT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_SAT_ALL);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (report_d && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
`else
  assign cnt = '0;
`endif

endmodule

// File: rtl/automata_monitor_stage.sv
// Monitor stage: symbol/reset forwarding pipeline, config decode and NUM_CH
// automaton channels. Report counters are built only with MONITOR_REPORT_CNT_EN.
module automata_monitor_stage
  import monitor_pkg::*;
#(
  parameter  int SYM_W      = 8,
  parameter  int NUM_CH     = 3,
  parameter  int NUM_ST     = 8,
  parameter  int CNT_W      = 16,
  parameter  int PIPE_DEPTH = 1,
  localparam int ST_W       = $clog2(NUM_ST),
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CFG_W      = cfg_width(SYM_W, ST_W)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic [SYM_W-1:0]        top_symbols,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [ST_W-1:0]         cfg_st,
  input  logic [CFG_W-1:0]        cfg_data,
  output logic                    cfg_rej,
  input  logic [NUM_CH-1:0]       clear_sticky,
  output logic [NUM_CH-1:0]       report,
  output logic [NUM_CH-1:0]       report_sticky,
  output logic [NUM_CH*CNT_W-1:0] report_cnt,
  output logic [SYM_W-1:0]        out_symbols,
  output logic                    out_reset
);

  logic                  cfg_ok;
  logic                  cfg_rej_q, cfg_rej_d;
  logic [SYM_W-1:0]      sym_q [PIPE_DEPTH];
  logic [SYM_W-1:0]      sym_d [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] rst_q, rst_d;

  always_comb begin
    // Tables may only change while the automata are frozen.
    cfg_ok    = !run && (32'(cfg_ch) < NUM_CH);
    cfg_rej_d = cfg_we && !cfg_ok;

    sym_d = sym_q;
    if (run) begin
      sym_d[0] = top_symbols;
      for (int i = 1; i < PIPE_DEPTH; i++) sym_d[i] = sym_q[i-1];
    end

    rst_d[0] = reset;
    for (int i = 1; i < PIPE_DEPTH; i++) rst_d[i] = rst_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_rej_q <= 1'b0;
      rst_q     <= '1;
      for (int i = 0; i < PIPE_DEPTH; i++) sym_q[i] <= '0;
    end else begin
      cfg_rej_q <= cfg_rej_d;
      rst_q     <= rst_d;
      sym_q     <= sym_d;
    end
  end

  assign cfg_rej     = cfg_rej_q;
  assign out_symbols = sym_q[PIPE_DEPTH-1];
  assign out_reset   = rst_q[PIPE_DEPTH-1];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    automata_dfa_channel #(
      .SYM_W  (SYM_W),
      .NUM_ST (NUM_ST),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .run     (run),
      .sym     (top_symbols),
      .wr_en   (cfg_we && cfg_ok && (cfg_ch == CH_W'(c))),
      .wr_st   (cfg_st),
      .wr_data (cfg_data),
      .clear   (clear_sticky[c]),
      .report  (report[c]),
      .sticky  (report_sticky[c]),
      .cnt     (report_cnt[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_automata_monitor_stage.sv
// Self-checking bench for automata_monitor_stage: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_automata_monitor_stage;
  import monitor_pkg::*;

  localparam int SYM_W   = 8;
  localparam int NUM_CH  = 3;
  localparam int NUM_ST  = 8;
  localparam int CNT_W   = 2;
  localparam int PD      = 1;
  localparam int ST_W    = 3;
  localparam int CH_W    = 2;
  localparam int CFG_W   = 2 * SYM_W + 2 * ST_W + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef MONITOR_REPORT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset, run, cfg_we;
  logic [SYM_W-1:0]        top_symbols;
  logic [CH_W-1:0]         cfg_ch;
  logic [ST_W-1:0]         cfg_st;
  logic [CFG_W-1:0]        cfg_data;
  logic [NUM_CH-1:0]       clear_sticky;
  logic                    cfg_rej, out_reset;
  logic [NUM_CH-1:0]       report, report_sticky;
  logic [NUM_CH*CNT_W-1:0] report_cnt;
  logic [SYM_W-1:0]        out_symbols;

  automata_monitor_stage #(
    .SYM_W(SYM_W), .NUM_CH(NUM_CH), .NUM_ST(NUM_ST), .CNT_W(CNT_W), .PIPE_DEPTH(PD)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .top_symbols(top_symbols),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_st(cfg_st), .cfg_data(cfg_data),
    .cfg_rej(cfg_rej), .clear_sticky(clear_sticky), .report(report),
    .report_sticky(report_sticky), .report_cnt(report_cnt),
    .out_symbols(out_symbols), .out_reset(out_reset)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: tables of entries, current states and per-channel outputs.
  mon_entry_t       m_tbl [NUM_CH][NUM_ST];
  int               m_st  [NUM_CH];
  int               m_cnt [NUM_CH];
  logic [NUM_CH-1:0] m_rep, m_stk;
  logic             m_rej;
  logic [SYM_W-1:0] m_symq [$];
  int               m_since_rst = 0;
  bit               m_valid = 1'b0;

  task automatic model_step();
    mon_entry_t e;
    bit ok, hit;
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int s = 0; s < NUM_ST; s++) m_tbl[c][s] = '0;
        m_st[c]  = 0;
        m_cnt[c] = 0;
      end
      m_rep = '0; m_stk = '0; m_rej = 1'b0;
      m_symq.delete();
      m_since_rst = 0;
      m_valid = 1'b1;
    end else begin
      ok = !run && (int'(cfg_ch) < NUM_CH);
      for (int c = 0; c < NUM_CH; c++) begin
        m_rep[c] = 1'b0;
        if (run) begin
          e = m_tbl[c][m_st[c]];
          hit = (top_symbols & e.match_mask) == (e.match_val & e.match_mask);
          m_st[c]  = hit ? int'(e.next_st) : int'(e.fail_st);
          m_rep[c] = m_tbl[c][m_st[c]].accept;
        end
        if (m_rep[c]) m_stk[c] = 1'b1;
        else if (clear_sticky[c]) m_stk[c] = 1'b0;
        if (m_rep[c] && m_cnt[c] < CNT_MAX) m_cnt[c]++;
      end
      m_rej = cfg_we && !ok;
      if (cfg_we && ok) m_tbl[cfg_ch][cfg_st] = mon_entry_t'(cfg_data);
      if (run) begin
        m_symq.push_back(top_symbols);
        if (m_symq.size() > PD) void'(m_symq.pop_front());
      end
      if (m_since_rst < 1000) m_since_rst++;
    end
  endtask

  function automatic logic [NUM_CH*CNT_W-1:0] exp_cnt();
    logic [NUM_CH*CNT_W-1:0] v = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (CNT_EN) v[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
    return v;
  endfunction

  function automatic logic [SYM_W-1:0] exp_sym();
    return (m_symq.size() >= PD) ? m_symq[m_symq.size() - PD] : '0;
  endfunction

  // Compare process: every cycle after the first reset edge.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("report",        64'(report),        64'(m_rep));
      check("report_sticky", 64'(report_sticky), 64'(m_stk));
      check("report_cnt",    64'(report_cnt),    64'(exp_cnt()));
      check("cfg_rej",       64'(cfg_rej),       64'(m_rej));
      check("out_symbols",   64'(out_symbols),   64'(exp_sym()));
      check("out_reset",     64'(out_reset),     64'(m_since_rst < PD));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic feed(input logic [SYM_W-1:0] s, input logic r);
    top_symbols = s;
    run = r;
    tick();
  endtask

  task automatic write_entry(input int ch, input int st, input logic [SYM_W-1:0] v,
                             input logic [SYM_W-1:0] m, input int nx, input int fl,
                             input bit acc);
    run = 1'b0; cfg_we = 1'b1;
    cfg_ch = CH_W'(ch); cfg_st = ST_W'(st);
    cfg_data = {v, m, ST_W'(nx), ST_W'(fl), acc};
    tick();
    cfg_we = 1'b0;
  endtask

  function automatic logic [CFG_W-1:0] rand_entry();
    return {SYM_W'($urandom_range(0, 15)), SYM_W'($urandom), ST_W'($urandom),
            ST_W'($urandom), ($urandom_range(0, 3) == 0)};
  endfunction

  function automatic logic [63:0] cnt_of(input int c);
    return 64'(report_cnt[c*CNT_W +: CNT_W]);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; run = 1'b1; top_symbols = 8'h41; cfg_we = 1'b0;
    cfg_ch = '0; cfg_st = '0; cfg_data = '0; clear_sticky = '0;

    // Reset for three cycles while symbols stream in.
    tick();
    check("rst_out_reset",  64'(out_reset),     64'd1);
    check("rst_report",     64'(report),        64'd0);
    check("rst_sticky",     64'(report_sticky), 64'd0);
    check("rst_out_sym",    64'(out_symbols),   64'd0);
    check("rst_cnt",        64'(report_cnt),    64'd0);
    feed(8'h42, 1'b1);
    feed(8'h41, 1'b1);
    check("rst_no_report",  64'(report),        64'd0);
    reset = 1'b0;
    feed(8'h00, 1'b0);
    check("rst_release",    64'(out_reset),     64'd0);

    // Single property on channel 0: 0x41 then 0x42 accepts.
    write_entry(0, 0, 8'h41, 8'hFF, 1, 0, 1'b0);
    write_entry(0, 1, 8'h42, 8'hFF, 2, 0, 1'b0);
    write_entry(0, 2, 8'h00, 8'h00, 0, 0, 1'b1);
    feed(8'h41, 1'b1);
    check("single_pre",     64'(report),        64'd0);
    feed(8'h42, 1'b1);
    check("single_report",  64'(report),        64'b001);
    check("single_out_sym", 64'(out_symbols),   64'h42);
    feed(8'h00, 1'b1);
    check("single_pulse",   64'(report),        64'd0);
    check("single_sticky",  64'(report_sticky), 64'b001);
    check("single_cnt",     cnt_of(0),          CNT_EN ? 64'd1 : 64'd0);

    // run gating: state and forwarded symbol hold while run=0.
    feed(8'h41, 1'b1);
    for (int i = 0; i < 4; i++) begin
      feed(SYM_W'($urandom), 1'b0);
      check("gate_out_sym", 64'(out_symbols), 64'h41);
      check("gate_report",  64'(report),      64'd0);
    end
    feed(8'h42, 1'b1);
    check("gate_report_after", 64'(report), 64'b001);

    // Config rejection: write while running, then to a nonexistent channel.
    top_symbols = 8'h00; run = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_st = 3'd0; cfg_data = '0;
    tick();
    check("rej_running", 64'(cfg_rej), 64'd1);
    run = 1'b0; cfg_ch = 2'd3; cfg_data = '1;
    tick();
    check("rej_bad_ch",  64'(cfg_rej), 64'd1);
    cfg_we = 1'b0;
    tick();
    check("rej_clear",   64'(cfg_rej), 64'd0);
    feed(8'h41, 1'b1);
    feed(8'h42, 1'b1);
    check("rej_table_kept", 64'(report), 64'b001);

    // Sticky race on channel 1: set wins over a same-edge clear.
    write_entry(1, 0, 8'h55, 8'hFF, 1, 0, 1'b0);
    write_entry(1, 1, 8'h00, 8'h00, 0, 0, 1'b1);
    clear_sticky = 3'b010;
    feed(8'h55, 1'b1);
    check("race_report", 64'(report[1]),        64'd1);
    check("race_sticky", 64'(report_sticky[1]), 64'd1);
    feed(8'h00, 1'b1);
    check("race_cleared", 64'(report_sticky[1]), 64'd0);
    clear_sticky = '0;

    // Saturation: five more accepts on channel 1.
    for (int i = 0; i < 5; i++) begin
      feed(8'h55, 1'b1);
      feed(8'h00, 1'b1);
    end
    check("sat_cnt", cnt_of(1), CNT_EN ? 64'd3 : 64'd0);

    // Reset mid-trace suppresses the report of that cycle's symbol.
    reset = 1'b1;
    feed(8'h55, 1'b1);
    check("midrst_report", 64'(report),        64'd0);
    check("midrst_sticky", 64'(report_sticky), 64'd0);
    check("midrst_cnt",    64'(report_cnt),    64'd0);
    reset = 1'b0;

    // Randomized phase: program every entry, then mix traffic, writes and resets.
    for (int c = 0; c < NUM_CH; c++)
      for (int s = 0; s < NUM_ST; s++) begin
        run = 1'b0; cfg_we = 1'b1; cfg_ch = CH_W'(c); cfg_st = ST_W'(s);
        cfg_data = rand_entry();
        tick();
      end
    cfg_we = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 599) == 0);
      run          = ($urandom_range(0, 1) == 0);
      top_symbols  = SYM_W'($urandom_range(0, 15));
      clear_sticky = NUM_CH'($urandom) & NUM_CH'($urandom) & NUM_CH'($urandom);
      cfg_we       = ($urandom_range(0, 5) == 0);
      cfg_ch       = CH_W'($urandom);
      cfg_st       = ST_W'($urandom);
      cfg_data     = rand_entry();
      tick();
    end

    reset = 1'b0; run = 1'b0; cfg_we = 1'b0; clear_sticky = '0;
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
